// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: per-stage flush/bubble resets and stall enables for an in-order pipeline
module pipeline_ctrl #(
    parameter int          NUM_STAGES    = 4,
    parameter int          INIT_CYCLES   = 4,
    parameter logic [31:0] BRU_MASK      = 32'b1100,
    parameter logic [31:0] JUMP_MASK     = 32'b0110,
    parameter logic [31:0] TRAP_MASK     = 32'b1111,
    parameter int          FLUSH_HOLD    = 0,
    parameter int          STALL_TIMEOUT = 255
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  bru_flush_in,
    input  logic                  jump_flush_in,
    input  logic                  trap_flush_in,
    input  logic [NUM_STAGES-1:0] stall_in,
    output logic [NUM_STAGES-1:0] pipeline_reset_out,
    output logic [NUM_STAGES-1:0] pipeline_enable_out,
    output logic                  init_busy_out,
    output logic                  stall_timeout_out,
    output logic [15:0]           flush_count_out
);
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam logic [NUM_STAGES-1:0] BM = BRU_MASK[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] JM = JUMP_MASK[NUM_STAGES-1:0];
    localparam logic [NUM_STAGES-1:0] TM = TRAP_MASK[NUM_STAGES-1:0];
    typedef enum logic {INIT, RUN} state_t;
    state_t                state;
    logic [IW-1:0]         init_cnt;
    logic [3:0]            hold_cnt;
    logic [NUM_STAGES-1:0] hold_mask, req_mask, flush_mask, region, front, bubble;
    logic [15:0]           stall_cnt, flush_cnt;
    logic                  timeout, stalling, run;
    always_comb begin
        req_mask   = (bru_flush_in ? BM : '0) | (jump_flush_in ? JM : '0) | (trap_flush_in ? TM : '0);
        flush_mask = req_mask | (hold_cnt != 4'd0 ? hold_mask : '0);
        region     = stall_in;
        for (int k = NUM_STAGES - 2; k >= 0; k--) region[k] = stall_in[k] | region[k+1];
        front      = region & ~(region >> 1);
        bubble     = ~region & (region << 1);
        stalling   = |stall_in && !(|(flush_mask & front));
        run        = reset_in && state == RUN;
    end
    assign pipeline_reset_out  = run ? (flush_mask | bubble) : '1;
    assign pipeline_enable_out = run ? (~region | flush_mask) : '0;
    assign init_busy_out       = !run;
    assign stall_timeout_out   = timeout;
    assign flush_count_out     = flush_cnt;
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state     <= INIT;
            init_cnt  <= IW'(INIT_CYCLES);
            hold_cnt  <= '0;
            hold_mask <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            timeout   <= 1'b0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt - 1'b1;
            if (init_cnt == IW'(1)) state <= RUN;
        end else begin
            if (FLUSH_HOLD > 0 && req_mask != '0) begin
                hold_mask <= req_mask | (hold_cnt != 4'd0 ? hold_mask : '0);
                hold_cnt  <= 4'(FLUSH_HOLD);
            end else if (hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 1'b1;
                if (hold_cnt == 4'd1) hold_mask <= '0;
            end
            if (req_mask != '0 && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 1'b1;
            stall_cnt <= stalling ? (stall_cnt == 16'hFFFF ? stall_cnt : stall_cnt + 1'b1) : '0;
            if (stalling && stall_cnt >= 16'(STALL_TIMEOUT - 1)) timeout <= 1'b1;
        end
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised pipeline control unit driving per-stage reset (flush/bubble) and enable (stall) for an N-register in-order pipeline.
- Successor to the fixed 4-stage combinational flush decoder.
- Adds:
  - a post-reset initialisation sequence;
  - configurable flush masks with a hold window;
  - per-stage stall requests with bubble insertion;
  - a stall watchdog;
  - a flush event counter.
- Sits beside the pipeline registers and receives flush requests from the BRU, jump unit and trap logic.

Parameters:
NUM_STAGES, 4, number of pipeline registers controlled; bit 0 = most upstream (fetch side), bit NUM_STAGES-1 = most downstream
INIT_CYCLES, 4, cycles all stage resets stay asserted after reset_in releases (>=1)
BRU_MASK, 4'b1100, stages reset on bru_flush_in
JUMP_MASK, 4'b0110, stages reset on jump_flush_in
TRAP_MASK, 4'b1111, stages reset on trap_flush_in
FLUSH_HOLD, 0, extra cycles a flush mask stays applied after the request cycle (0..15)
STALL_TIMEOUT, 255, consecutive stalled cycles before watchdog fires (>=1, <2^16)

Ports:
clock_in  input  1  single clock, all state updates on rising edge
reset_in  input  1  synchronous, active-low reset
bru_flush_in  input  1  branch misprediction flush request
jump_flush_in  input  1  jump flush request
trap_flush_in  input  1  trap/exception flush request
stall_in  input  NUM_STAGES  stall_in[k]=1: register k must hold its contents this cycle
pipeline_reset_out  output  NUM_STAGES  per-register synchronous clear
pipeline_enable_out  output  NUM_STAGES  per-register load enable
init_busy_out  output  1  high during initialisation sequence
stall_timeout_out  output  1  sticky watchdog flag
flush_count_out  output  16  saturating count of flush cycles

Behaviour:
- Reset (reset_in=0 at a rising edge):
  - FSM enters INIT; init counter loads INIT_CYCLES.
  - Hold counter, stall counter and flush count clear; stall_timeout_out clears.
- Output values while reset_in=0 (combinational on reset_in):
  - pipeline_reset_out = all ones; pipeline_enable_out = all zeros; init_busy_out = 1.
- INIT state:
  - Outputs are reset all ones, enable all zeros, init_busy_out=1.
  - Counter decrements each cycle; on the cycle it reaches 1, the next state is RUN.
  - Exactly INIT_CYCLES INIT cycles follow reset release.
  - Flush and stall inputs are ignored.
- RUN state, flush handling (combinational, zero latency):
  - req_mask = (bru?BRU_MASK:0) | (jump?JUMP_MASK:0) | (trap?TRAP_MASK:0).
  - Simultaneous requests OR together; there is no priority loss.
- Flush hold window:
  - When FLUSH_HOLD>0 and req_mask!=0, hold_mask <= req_mask | (hold_counter>0 ? hold_mask : 0) and hold_counter <= FLUSH_HOLD.
  - Otherwise hold_counter decrements to 0; hold_mask clears when the counter reaches 0.
  - flush_mask = req_mask | hold_mask (hold_mask counts only while hold_counter>0).
- Stall handling:
  - stall_front = highest index k with stall_in[k]=1.
  - Registers 0..stall_front get enable=0.
  - Register stall_front+1 (if it exists) gets reset=1 as a bubble.
  - All other registers get enable=1.
  - With no stall, all enables are 1.
- Flush vs. stall: for each bit with flush_mask=1, reset=1 and enable=1. Flush overrides stall.
- Output composition: pipeline_reset_out = flush_mask | bubble_mask; init_busy_out=0 in RUN.
- flush_count_out:
  - Increments by 1 in each RUN cycle with req_mask!=0.
  - Saturates at 16'hFFFF; hold cycles are not counted.
- Stall watchdog:
  - stall_cnt increments in each RUN cycle with |stall_in and no flush_mask bit on stall_front.
  - It clears otherwise.
  - When stall_cnt reaches STALL_TIMEOUT, stall_timeout_out <= 1 and stays 1 until reset.
  - stall_cnt saturates.
- Reset mid-operation: any cycle with reset_in=0 returns to INIT and discards hold and stall state, regardless of pending flushes.
- Widths: all masks are NUM_STAGES bits. Mask parameters wider than NUM_STAGES are truncated (LSBs kept).

Test Plan:
- Reset low 3 cycles, then high, INIT_CYCLES=4 -> reset_out=4'b1111, enable_out=4'b0000, init_busy_out=1 for exactly 4 cycles after release; then reset_out=0000, enable_out=1111, busy=0.
- RUN, bru_flush_in and jump_flush_in high same cycle -> reset_out=4'b1110 that cycle, 0000 next cycle; flush_count_out 0->1.
- FLUSH_HOLD=2, jump pulse 1 cycle, then bru pulse 1 cycle later -> reset_out 0110, 1110, 1110, 1110, 0000.
- stall_in=4'b0010 for 3 cycles -> enable_out=1100, reset_out=0100 each cycle; with trap_flush_in high on cycle 2 -> reset_out=1111, enable_out=1111.
- STALL_TIMEOUT=5, stall_in=0001 held 10 cycles -> stall_timeout_out rises after 5th stalled cycle, stays 1 after stall drops, clears only on reset_in=0.
- Reset asserted while hold_counter=2 and stall active -> next cycle INIT outputs; after INIT, no residual flush/hold; flush_count_out=0.
